// File: rtl/calc_display_driver.sv
// calc_display_driver: 8-bit result to BCD via sequential double-dabble, driving a
// multiplexed 4-digit seven-segment display (sign, hundreds, tens, units).
module calc_display_driver #(
   parameter int SCAN_DIV = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  value_in,
   input  logic        signed_mode,
   output logic [6:0]  seg,
   output logic [3:0]  digit_en,
   output logic [11:0] bcd,
   output logic        neg,
   output logic        busy,
   output logic        conv_done
);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t      state_q, state_d;
   logic [8:0]  last_q, last_d;
   logic [7:0]  mag_q, mag_d;
   logic [11:0] work_q, work_d, adj;
   logic [2:0]  cnt_q, cnt_d;
   logic        negp_q, negp_d;
   logic [11:0] bcd_q, bcd_d;
   logic        neg_q, neg_d, done_q, done_d;
   logic [15:0] scan_q, scan_d;
   logic [1:0]  idx_q, idx_d;
   logic        wrap;
   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: dec = 7'h3F;
         4'd1: dec = 7'h06;
         4'd2: dec = 7'h5B;
         4'd3: dec = 7'h4F;
         4'd4: dec = 7'h66;
         4'd5: dec = 7'h6D;
         4'd6: dec = 7'h7D;
         4'd7: dec = 7'h07;
         4'd8: dec = 7'h7F;
         4'd9: dec = 7'h6F;
         default: dec = 7'h00;
      endcase
   endfunction
   assign adj = {work_q[11:8] >= 4'd5 ? work_q[11:8] + 4'd3 : work_q[11:8],
                 work_q[7:4]  >= 4'd5 ? work_q[7:4]  + 4'd3 : work_q[7:4],
                 work_q[3:0]  >= 4'd5 ? work_q[3:0]  + 4'd3 : work_q[3:0]};
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      mag_d   = mag_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      negp_d  = negp_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if ({signed_mode, value_in} != last_q) begin
            last_d  = {signed_mode, value_in};
            negp_d  = signed_mode & value_in[7];
            mag_d   = (signed_mode & value_in[7]) ? ~value_in + 8'd1 : value_in;
            work_d  = '0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            {work_d, mag_d} = {adj, mag_q} << 1;
            cnt_d = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd7) ? COMMIT : SHIFT;
         end
         COMMIT: begin
            bcd_d   = work_q;
            neg_d   = negp_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign wrap   = scan_q == 16'(SCAN_DIV - 1);
   assign scan_d = wrap ? '0 : scan_q + 16'd1;
   assign idx_d  = wrap ? idx_q - 2'd1 : idx_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= '0;
         mag_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         negp_q  <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
         scan_q  <= '0;
         idx_q   <= 2'd3;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         mag_q   <= mag_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         negp_q  <= negp_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
      end
   end
   assign bcd       = bcd_q;
   assign neg       = neg_q;
   assign busy      = state_q != IDLE;
   assign conv_done = done_q;
   assign digit_en  = 4'b0001 << idx_q;
   // leading-zero blanking: tens only blanks when hundreds is blank too
   assign seg = idx_q == 2'd3 ? (neg_q ? 7'h40 : 7'h00) :
                idx_q == 2'd2 ? (bcd_q[11:8] == 4'd0 ? 7'h00 : dec(bcd_q[11:8])) :
                idx_q == 2'd1 ? (bcd_q[11:4] == 8'd0 ? 7'h00 : dec(bcd_q[7:4])) :
                dec(bcd_q[3:0]);
endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: directed stimulus with a result scoreboard popped on conv_done.
module tb_calc_display_driver;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  value_in = 8'h00;
   logic        signed_mode = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  digit_en;
   logic [11:0] bcd;
   logic        neg, busy, conv_done;
   int          checks = 0;
   int          errors = 0;
   logic [12:0] sb[$];
   logic [12:0] prev = '0;
   logic [12:0] e;
   int          busy_seen;
   calc_display_driver #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .signed_mode(signed_mode),
      .seg(seg), .digit_en(digit_en), .bcd(bcd), .neg(neg), .busy(busy), .conv_done(conv_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) if (conv_done) begin
      if (sb.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else begin
         e = sb.pop_front();
         chk("sb_result", 32'({neg, bcd}), 32'(e));
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run_conv(input logic [7:0] v, input logic s, input logic [12:0] exp);
      value_in = v;
      signed_mode = s;
      sb.push_back(exp);
      for (int k = 0; k <= 10; k++) begin
         tick();
         chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= 8));
         chk($sformatf("done_k%0d", k), 32'(conv_done), 32'(k == 9));
         if (k < 9) chk("hold_prev", 32'({neg, bcd}), 32'(prev));
      end
      prev = exp;
   endtask
   task automatic check_digits(input logic [6:0] e3, e2, e1, e0);
      logic [7:0] ex;
      for (int n = 0; n < 16; n++) begin
         tick();
         ex = digit_en == 4'b1000 ? {1'b0, e3} : digit_en == 4'b0100 ? {1'b0, e2} :
              digit_en == 4'b0010 ? {1'b0, e1} : digit_en == 4'b0001 ? {1'b0, e0} : 8'hFF;
         chk($sformatf("seg_en%b", digit_en), 32'(seg), 32'(ex));
      end
   endtask
   initial begin
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(conv_done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
      chk("rst_digit_en", 32'(digit_en), 32'b1000);
      chk("rst_seg", 32'(seg), 32'd0);
      rst = 1'b0;
      #1;
      busy_seen = 0;
      for (int k = 0; k < 50; k++) begin
         if (k > 0) tick();
         if (k < 20) chk($sformatf("scan_k%0d", k), 32'(digit_en), 32'(4'b1000 >> ((k / 4) % 4)));
         if (busy) busy_seen++;
      end
      chk("zero_no_busy", 32'(busy_seen), 32'd0);
      chk("zero_bcd", 32'(bcd), 32'd0);
      check_digits(7'h00, 7'h00, 7'h00, 7'h3F);
      run_conv(8'd123, 1'b0, {1'b0, 12'h123});
      check_digits(7'h00, 7'h06, 7'h5B, 7'h4F);
      run_conv(8'hFF, 1'b1, {1'b1, 12'h001});
      check_digits(7'h40, 7'h00, 7'h00, 7'h06);
      run_conv(8'h80, 1'b1, {1'b1, 12'h128});
      check_digits(7'h40, 7'h06, 7'h5B, 7'h7F);
      run_conv(8'h80, 1'b0, {1'b0, 12'h128});
      run_conv(8'd255, 1'b0, {1'b0, 12'h255});
      run_conv(8'd10, 1'b1, {1'b0, 12'h010});
      check_digits(7'h00, 7'h00, 7'h06, 7'h3F);
      value_in = 8'd200;
      signed_mode = 1'b0;
      sb.push_back({1'b0, 12'h200});
      for (int k = 0; k <= 20; k++) begin
         tick();
         if (k == 3) begin
            value_in = 8'd7;
            sb.push_back({1'b0, 12'h007});
         end
         chk($sformatf("retrig_done_k%0d", k), 32'(conv_done), 32'(k == 9 || k == 19));
      end
      chk("retrig_bcd", 32'(bcd), 32'h007);
      value_in = 8'd99;
      for (int k = 0; k <= 4; k++) tick();
      chk("pre_abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_bcd", 32'({neg, bcd}), 32'd0);
      chk("abort_digit_en", 32'(digit_en), 32'b1000);
      tick();
      rst = 1'b0;
      sb.push_back({1'b0, 12'h099});
      for (int k = 1; k <= 11; k++) begin
         tick();
         chk($sformatf("rerun_done_k%0d", k), 32'(conv_done), 32'(k == 10));
      end
      chk("rerun_bcd", 32'(bcd), 32'h099);
      tick();
      tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/calc_display_driver.md
CALC_DISPLAY_DRIVER -- requirements
Module: calc_display_driver

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter SCAN_DIV, default 1024, SHALL set the clock cycles each digit is driven (legal range 2..65535).
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge system clock.
REQ-004 Port rst, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-005 Port value_in, input, 8 bits, SHALL carry the calculator result register.
REQ-006 Port signed_mode, input, 1 bit, SHALL select two's-complement display (1) or unsigned display (0).
REQ-007 Port seg, output, 7 bits, SHALL drive active-high segments {g,f,e,d,c,b,a}, with bit 0 = a.
REQ-008 Port digit_en, output, 4 bits, SHALL give an active-high one-hot digit select, bit 3 = leftmost (sign).
REQ-009 Port bcd, output, 12 bits, SHALL give the committed {hundreds, tens, units} BCD magnitude.
REQ-010 Port neg, output, 1 bit, SHALL give the committed sign flag.
REQ-011 Port busy, output, 1 bit, SHALL be high while a conversion is in progress.
REQ-012 Port conv_done, output, 1 bit, SHALL pulse high for one cycle after each commit.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and COMMIT.
REQ-014 In IDLE, at an edge where {signed_mode, value_in} differs from the last captured pair, the block SHALL capture the pair and go to SHIFT with iteration count 0.
REQ-015 Capture magnitude: value_in unchanged if signed_mode=0 or value_in[7]=0; otherwise the 8-bit two's-complement negation (0x80 -> 128) with neg_pending=1.
REQ-016 SHIFT SHALL run sequential double-dabble for exactly 8 cycles (add 3 to any BCD nibble >=5, then shift left 1), then go to COMMIT.
REQ-017 COMMIT SHALL load bcd and neg atomically on its edge, return to IDLE, and assert conv_done in the following cycle.
REQ-018 Latency: capture at edge E, shifts at E+1..E+8, commit at E+9, conv_done high during cycle E+9..E+10.
REQ-019 busy SHALL be high in SHIFT and COMMIT, and low in IDLE.
REQ-020 Input changes during SHIFT or COMMIT SHALL be ignored; on return to IDLE the compare of REQ-014 SHALL retrigger at the next edge if the inputs still differ.
REQ-021 bcd and neg SHALL hold their previous values until a commit; no partial result is ever visible.
REQ-022 A scan counter SHALL count 0..SCAN_DIV-1 and, on wrap, advance the digit index 3->2->1->0->3; digit_en SHALL equal one-hot(index) at all times.
REQ-023 Digit 3 SHALL show minus (0x40) if neg=1, else blank (0x00).
REQ-024 Digit 2 (hundreds) SHALL be blank when 0.
REQ-025 Digit 1 (tens) SHALL be blank when both hundreds and tens are 0.
REQ-026 Digit 0 (units) SHALL always be shown.
REQ-027 Segment codes 0-9 SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-028 seg SHALL be decoded combinationally from the committed registers and the digit index, and SHALL change only when the index or the committed value changes.
REQ-029 Scanning SHALL run continuously and independently of conversion.

Reset
REQ-030 While rst=1, asynchronously:
- state = IDLE
- last captured pair = {0, 0x00}
- bcd = 000, neg = 0
- busy = 0, conv_done = 0
- scan counter = 0, digit index = 3
- digit_en = 4'b1000, seg = 0x00
REQ-031 Reset asserted mid-conversion SHALL abort it with no commit; after release the block SHALL re-convert if inputs differ from {0, 0x00}.
REQ-032 After reset with value_in=0 and signed_mode=0, no conversion SHALL start.

Verification
REQ-033 Reset, then value_in=0x00 for 50 cycles -> busy never asserts; bcd=000; units digit seg=3F; other digits 0x00.
REQ-034 value_in=123 unsigned -> busy for 9 cycles; conv_done at E+9; bcd=0x123, neg=0; SCAN_DIV=4 shows blank, 06, 5B, 4F across digits 3..0.
REQ-035 signed_mode=1, value_in=0xFF -> bcd=0x001, neg=1; digit 3 = 40, digits 2 and 1 blank, digit 0 = 06. Then value_in=0x80 -> bcd=0x128, neg=1.
REQ-036 value_in=200, then value_in=7 at E+3 -> first commit bcd=0x200; second conversion starts at E+10 and commits bcd=0x007.
REQ-037 rst pulsed at E+4 during the conversion of 99 -> outputs return to reset values with no conv_done; after release a conversion of 99 completes 10 cycles later.
REQ-038 SCAN_DIV=4 -> digit_en sequence 1000, 0100, 0010, 0001, each held exactly 4 cycles, repeating.
